// File: rtl/i3c_ahb_manager.sv
// AHB-Lite manager for the I3C core's AHB subordinate port.
// Turns a valid/ready command stream into single transfers, one in flight,
// with alignment checking and a data-phase watchdog that drains a stuck bus.
module i3c_ahb_manager #(
   parameter int unsigned AhbAddrWidth  = 32,
   parameter int unsigned AhbDataWidth  = 64,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [AhbAddrWidth-1:0]   cmd_addr_i,
   input  logic [2:0]                cmd_size_i,
   input  logic [AhbDataWidth-1:0]   cmd_wdata_i,
   input  logic [AhbDataWidth/8-1:0] cmd_wstrb_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [AhbDataWidth-1:0]   rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   output logic [AhbAddrWidth-1:0]   haddr_o,
   output logic [2:0]                hburst_o,
   output logic [3:0]                hprot_o,
   output logic [2:0]                hsize_o,
   output logic [1:0]                htrans_o,
   output logic                      hwrite_o,
   output logic [AhbDataWidth-1:0]   hwdata_o,
   output logic [AhbDataWidth/8-1:0] hwstrb_o,
   output logic                      hsel_o,
   output logic                      hready_o,
   input  logic [AhbDataWidth-1:0]   hrdata_i,
   input  logic                      hreadyout_i,
   input  logic                      hresp_i
);

   localparam int unsigned StrbWidth = AhbDataWidth / 8;
   localparam int unsigned MaxSize   = $clog2(StrbWidth);
   localparam int unsigned CntWidth  = $clog2(TimeoutCycles) + 1;
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransNonseq = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
      StErr,
      StResp,
      StDrain
   } state_e;

   state_e                    state;
   logic [AhbAddrWidth-1:0]   addr_q;
   logic [2:0]                size_q;
   logic                      write_q;
   logic [AhbDataWidth-1:0]   wdata_q;
   logic [StrbWidth-1:0]      wstrb_q;
   logic [AhbDataWidth-1:0]   rdata_q;
   logic                      err_q;
   logic                      timeout_q;
   logic                      busy_q;        // bus still owes us a completion after a timeout
   logic                      drain_addr_q;  // timed-out address phase not yet accepted
   logic [CntWidth-1:0]       wdog_q;

   logic [AhbAddrWidth-1:0]   align_mask;
   logic                      cmd_legal;
   logic                      addr_phase;
   logic                      data_phase;
   logic                      wdog_expired;

   assign align_mask   = (AhbAddrWidth'(1) << cmd_size_i) - AhbAddrWidth'(1);
   assign cmd_legal    = (cmd_size_i <= 3'(MaxSize)) && ((cmd_addr_i & align_mask) == '0);
   assign addr_phase   = (state == StAddr) || ((state == StDrain) && drain_addr_q);
   assign data_phase   = (state == StData) || (state == StErr) ||
                         ((state == StDrain) && !drain_addr_q);
   assign wdog_expired = (wdog_q == CntLast);

   assign cmd_ready_o   = (state == StIdle);
   assign rsp_valid_o   = (state == StResp);
   assign rsp_rdata_o   = rdata_q;
   assign rsp_err_o     = err_q;
   assign rsp_timeout_o = timeout_q;
   assign htrans_o      = addr_phase ? TransNonseq : TransIdle;
   assign hsel_o        = addr_phase;
   assign haddr_o       = addr_phase ? addr_q : '0;
   assign hsize_o       = addr_phase ? size_q : 3'b000;
   assign hwrite_o      = addr_phase ? write_q : 1'b0;
   assign hwdata_o      = (data_phase && write_q) ? wdata_q : '0;
   assign hwstrb_o      = (data_phase && write_q) ? wstrb_q : '0;
   assign hburst_o      = 3'b000;
   assign hprot_o       = 4'b0011;
   assign hready_o      = hreadyout_i;

   // Transfer sequencer, watchdog and response holding registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= StIdle;
         addr_q       <= '0;
         size_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
         busy_q       <= 1'b0;
         drain_addr_q <= 1'b0;
         wdog_q       <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (cmd_valid_i) begin
                  addr_q  <= cmd_addr_i;
                  size_q  <= cmd_size_i;
                  write_q <= cmd_write_i;
                  wdata_q <= cmd_wdata_i;
                  wstrb_q <= cmd_wstrb_i;
                  wdog_q  <= '0;
                  if (cmd_legal) begin
                     state <= StAddr;
                  end else begin
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                     state   <= StResp;
                  end
               end
            end
            StAddr: begin
               wdog_q <= wdog_q + CntWidth'(1);
               if (wdog_expired) begin
                  // Address phase may have been accepted on this very edge
                  timeout_q    <= 1'b1;
                  err_q        <= 1'b0;
                  rdata_q      <= '0;
                  busy_q       <= 1'b1;
                  drain_addr_q <= !hreadyout_i;
                  state        <= StResp;
               end else if (hreadyout_i) begin
                  state <= StData;
               end
            end
            StData: begin
               wdog_q <= wdog_q + CntWidth'(1);
               if (hreadyout_i) begin
                  // hresp with hready in the first error cycle is a protocol
                  // violation; still complete it as an error
                  err_q   <= hresp_i;
                  rdata_q <= (write_q || hresp_i) ? '0 : hrdata_i;
                  state   <= StResp;
               end else if (wdog_expired) begin
                  timeout_q    <= 1'b1;
                  err_q        <= 1'b0;
                  rdata_q      <= '0;
                  busy_q       <= 1'b1;
                  drain_addr_q <= 1'b0;
                  state        <= StResp;
               end else if (hresp_i) begin
                  state <= StErr;
               end
            end
            StErr: begin
               wdog_q <= wdog_q + CntWidth'(1);
               if (hreadyout_i) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state   <= StResp;
               end else if (wdog_expired) begin
                  timeout_q    <= 1'b1;
                  err_q        <= 1'b0;
                  rdata_q      <= '0;
                  busy_q       <= 1'b1;
                  drain_addr_q <= 1'b0;
                  state        <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready_i) begin
                  rdata_q   <= '0;
                  err_q     <= 1'b0;
                  timeout_q <= 1'b0;
                  state     <= busy_q ? StDrain : StIdle;
               end
            end
            StDrain: begin
               // Finish the abandoned transfer; its result is discarded
               if (drain_addr_q) begin
                  if (hreadyout_i) drain_addr_q <= 1'b0;
               end else if (hreadyout_i) begin
                  busy_q <= 1'b0;
                  state  <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_i3c_ahb_manager.sv
// Directed bench for i3c_ahb_manager: vector table plus timeout/drain and
// asynchronous reset sequences, against a reactive AHB subordinate model.
module tb_i3c_ahb_manager;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int SW = DW / 8;
   localparam int TO = 16;
   localparam logic [1:0] NS = 2'b10;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic          cmd_write_i;
   logic [AW-1:0] cmd_addr_i;
   logic [2:0]    cmd_size_i;
   logic [DW-1:0] cmd_wdata_i;
   logic [SW-1:0] cmd_wstrb_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;
   logic          rsp_timeout_o;
   logic [AW-1:0] haddr_o;
   logic [2:0]    hburst_o;
   logic [3:0]    hprot_o;
   logic [2:0]    hsize_o;
   logic [1:0]    htrans_o;
   logic          hwrite_o;
   logic [DW-1:0] hwdata_o;
   logic [SW-1:0] hwstrb_o;
   logic          hsel_o;
   logic          hready_o;
   logic [DW-1:0] hrdata_i;
   logic          hreadyout_i;
   logic          hresp_i;

   int n_checks = 0;
   int n_fail   = 0;

   // subordinate model configuration
   int            sub_wait  = 0;
   int            sub_mode  = 0;   // 0 = OKAY, 1 = two-cycle ERROR
   logic          sub_stall = 1'b0;
   logic [DW-1:0] sub_rdata = '0;
   logic          sub_dp    = 1'b0;
   int            sub_cnt   = 0;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [2:0]    size;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      int            waits;
      int            mode;
      logic [DW-1:0] rdata;
      int            hold;
      int            exp_lat;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
      int            exp_nonseq;
   } vec_t;

   vec_t vecs[10];

   always #5 clk_i = ~clk_i;

   i3c_ahb_manager #(
      .AhbAddrWidth (AW),
      .AhbDataWidth (DW),
      .TimeoutCycles(TO)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_write_i  (cmd_write_i),
      .cmd_addr_i   (cmd_addr_i),
      .cmd_size_i   (cmd_size_i),
      .cmd_wdata_i  (cmd_wdata_i),
      .cmd_wstrb_i  (cmd_wstrb_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o),
      .rsp_timeout_o(rsp_timeout_o),
      .haddr_o      (haddr_o),
      .hburst_o     (hburst_o),
      .hprot_o      (hprot_o),
      .hsize_o      (hsize_o),
      .htrans_o     (htrans_o),
      .hwrite_o     (hwrite_o),
      .hwdata_o     (hwdata_o),
      .hwstrb_o     (hwstrb_o),
      .hsel_o       (hsel_o),
      .hready_o     (hready_o),
      .hrdata_i     (hrdata_i),
      .hreadyout_i  (hreadyout_i),
      .hresp_i      (hresp_i)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reactive subordinate: drives its inputs at the falling edge for the coming rising edge
   initial begin
      hreadyout_i = 1'b1;
      hresp_i     = 1'b0;
      hrdata_i    = '0;
      forever begin
         @(negedge clk_i);
         hreadyout_i = 1'b1;
         hresp_i     = 1'b0;
         hrdata_i    = '0;
         if (!rst_ni) begin
            sub_dp = 1'b0;
         end else if (sub_dp) begin
            if (sub_stall) begin
               hreadyout_i = 1'b0;
            end else if (sub_mode == 1) begin
               hresp_i     = 1'b1;
               hrdata_i    = sub_rdata;
               hreadyout_i = (sub_cnt != 0);
               if (sub_cnt != 0) sub_dp = 1'b0;
               sub_cnt++;
            end else if (sub_cnt < sub_wait) begin
               hreadyout_i = 1'b0;
               sub_cnt++;
            end else begin
               hrdata_i = sub_rdata;
               sub_dp   = 1'b0;
            end
         end else if (htrans_o == NS) begin
            if (sub_stall) begin
               hreadyout_i = 1'b0;
            end else begin
               sub_dp  = 1'b1;
               sub_cnt = 0;
            end
         end
      end
   end

   // Issue one command, measure latency, check response and bus activity, then handshake
   task automatic run_vec(input vec_t v, input string tag);
      int            lat;
      int            nonseq;
      logic          prev_ns;
      logic [DW-1:0] dw;
      logic [SW-1:0] ds;
      logic          bad;
      sub_wait    = v.waits;
      sub_mode    = v.mode;
      sub_rdata   = v.rdata;
      cmd_write_i = v.wr;
      cmd_addr_i  = v.addr;
      cmd_size_i  = v.size;
      cmd_wdata_i = v.wdata;
      cmd_wstrb_i = v.wstrb;
      cmd_valid_i = 1'b1;
      check({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'(1));
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      lat = 1; nonseq = 0; prev_ns = 1'b0; dw = '0; ds = '0;
      while (!rsp_valid_o && lat < 50) begin
         if (prev_ns) begin
            dw = hwdata_o;
            ds = hwstrb_o;
         end
         prev_ns = (htrans_o == NS);
         if (prev_ns) nonseq++;
         @(negedge clk_i);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
      check({tag, "_err"}, 64'(rsp_err_o), 64'(v.exp_err));
      check({tag, "_timeout"}, 64'(rsp_timeout_o), 64'(0));
      check({tag, "_rdata"}, rsp_rdata_o, v.exp_rdata);
      check({tag, "_nonseq_cycles"}, 64'(nonseq), 64'(v.exp_nonseq));
      check({tag, "_hwdata"}, dw, (v.wr && v.exp_nonseq != 0) ? v.wdata : 64'h0);
      check({tag, "_hwstrb"}, 64'(ds), (v.wr && v.exp_nonseq != 0) ? 64'(v.wstrb) : 64'h0);
      if (v.hold > 0) begin
         bad = 1'b0;
         cmd_valid_i = 1'b1;
         for (int i = 0; i < v.hold; i++) begin
            @(negedge clk_i);
            if (!rsp_valid_o || rsp_rdata_o !== v.exp_rdata || rsp_err_o !== v.exp_err ||
                cmd_ready_o || htrans_o != 2'b00) bad = 1'b1;
         end
         cmd_valid_i = 1'b0;
         check({tag, "_held_stable"}, 64'(bad), 64'(0));
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      check({tag, "_post_cmd_ready"}, 64'(cmd_ready_o), 64'(1));
      check({tag, "_post_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
      check({tag, "_post_cleared"}, 64'({rsp_err_o, rsp_timeout_o}) | rsp_rdata_o, 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      int   lat;
      int   nonseq;
      int   n;
      logic bad;

      vecs[0] = '{1'b1, 32'h100, 3'd3, 64'h1122334455667788, 8'hFF, 0, 0, 64'h0, 0, 3, 1'b0, 64'h0, 1};
      vecs[1] = '{1'b0, 32'h104, 3'd2, 64'h0, 8'h00, 2, 0, 64'hDEADBEEF, 10, 5, 1'b0, 64'hDEADBEEF, 1};
      vecs[2] = '{1'b0, 32'h200, 3'd3, 64'h0, 8'h00, 0, 1, 64'hCAFEF00D, 0, 4, 1'b1, 64'h0, 1};
      vecs[3] = '{1'b1, 32'h102, 3'd2, 64'h55, 8'h0F, 0, 0, 64'h0, 0, 1, 1'b1, 64'h0, 0};
      vecs[4] = '{1'b0, 32'h0, 3'd4, 64'h0, 8'h00, 0, 0, 64'h0, 0, 1, 1'b1, 64'h0, 0};
      vecs[5] = '{1'b1, 32'h300, 3'd2, 64'hAABBCCDD, 8'h0F, 0, 1, 64'h0, 0, 4, 1'b1, 64'h0, 1};
      vecs[6] = '{1'b0, 32'h108, 3'd3, 64'h0, 8'h00, 0, 0, 64'h0123456789ABCDEF, 0, 3, 1'b0, 64'h0123456789ABCDEF, 1};
      vecs[7] = '{1'b1, 32'h10, 3'd0, 64'h5A, 8'h01, 1, 0, 64'h0, 0, 4, 1'b0, 64'h0, 1};
      vecs[8] = '{1'b0, 32'h6, 3'd1, 64'h0, 8'h00, 0, 0, 64'hA5A5, 0, 3, 1'b0, 64'hA5A5, 1};
      vecs[9] = '{1'b0, 32'h3, 3'd1, 64'h0, 8'h00, 0, 0, 64'h0, 0, 1, 1'b1, 64'h0, 0};

      rst_ni      = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_size_i  = '0;
      cmd_wdata_i = '0;
      cmd_wstrb_i = '0;
      rsp_ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("reset_cmd_ready", 64'(cmd_ready_o), 64'(1));
      check("reset_rsp_valid", 64'(rsp_valid_o), 64'(0));
      check("reset_htrans_hsel", 64'({htrans_o, hsel_o}), 64'(0));
      check("reset_haddr", 64'(haddr_o), 64'(0));
      check("reset_hwdata", hwdata_o, 64'(0));
      rst_ni = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Watchdog: subordinate stalls the address phase for about 40 cycles
      sub_stall   = 1'b1;
      sub_mode    = 1;
      sub_rdata   = 64'hBAD0BAD0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 32'h40;
      cmd_size_i  = 3'd3;
      cmd_valid_i = 1'b1;
      check("to_cmd_ready", 64'(cmd_ready_o), 64'(1));
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      lat = 1; nonseq = 0;
      while (!rsp_valid_o && lat < 40) begin
         if (htrans_o == NS) nonseq++;
         @(negedge clk_i);
         lat++;
      end
      check("to_latency", 64'(lat), 64'(TO + 1));
      check("to_timeout", 64'(rsp_timeout_o), 64'(1));
      check("to_err", 64'(rsp_err_o), 64'(0));
      check("to_rdata", rsp_rdata_o, 64'(0));
      check("to_nonseq_cycles", 64'(nonseq), 64'(TO));
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      lat++;
      bad = 1'b0;
      while (lat < 40) begin
         if (cmd_ready_o || rsp_valid_o || htrans_o != NS || haddr_o != 32'h40) bad = 1'b1;
         @(negedge clk_i);
         lat++;
      end
      check("drain_addr_held", 64'(bad), 64'(0));
      sub_stall = 1'b0;
      n = 0; bad = 1'b0;
      while (!cmd_ready_o && n < 20) begin
         if (rsp_valid_o) bad = 1'b1;
         @(negedge clk_i);
         n++;
      end
      check("drain_done_cmd_ready", 64'(cmd_ready_o), 64'(1));
      check("drain_late_resp_ignored", 64'(bad), 64'(0));
      run_vec(vecs[6], "after_drain");

      // Asynchronous reset in the middle of a data phase
      sub_wait    = 5;
      sub_mode    = 0;
      sub_rdata   = 64'h77;
      cmd_write_i = 1'b1;
      cmd_addr_i  = 32'h20;
      cmd_size_i  = 3'd3;
      cmd_wdata_i = 64'h99;
      cmd_wstrb_i = 8'hFF;
      cmd_valid_i = 1'b1;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      @(negedge clk_i);
      check("mid_data_hwdata", hwdata_o, 64'h99);
      check("mid_data_cmd_ready", 64'(cmd_ready_o), 64'(0));
      #2 rst_ni = 1'b0;
      #1;
      check("async_rst_htrans_hsel", 64'({htrans_o, hsel_o}), 64'(0));
      check("async_rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
      check("async_rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
      check("async_rst_hwdata", hwdata_o, 64'(0));
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_vec(vecs[0], "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
